vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, VRAM address width.
REQ-002 Parameter STARVE_MAX, default 8, maximum number of consecutive cycles a pending CPU request may lose to video.
REQ-003 Ports are listed below as name, direction, width, meaning.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vid_req  in  1  video fetch request; held until granted.
REQ-007 vid_addr  in  ADDR_W  video fetch address.
REQ-008 vid_gnt  out  1  combinational; video owns VRAM this cycle.
REQ-009 vid_rvalid  out  1  registered; vid_rdata valid.
REQ-010 vid_rdata  out  8  video read data.
REQ-011 cpu_req  in  1  CPU access request; held, with stable cpu_we/addr/wdata, until cpu_ack.
REQ-012 cpu_we  in  1  1 = write, 0 = read.
REQ-013 cpu_addr  in  ADDR_W  CPU address.
REQ-014 cpu_wdata  in  8  CPU write data.
REQ-015 cpu_ack  out  1  one-cycle completion pulse.
REQ-016 cpu_rdata  out  8  read data; valid while cpu_ack=1.
REQ-017 fill_start  in  1  pulse; starts a fill.
REQ-018 fill_value  in  8  fill byte; sampled at start.
REQ-019 fill_len  in  ADDR_W  bytes to fill; sampled at start.
REQ-020 fill_busy  out  1  fill in progress.
REQ-021 mem_en  out  1  VRAM port enable.
REQ-022 mem_we  out  1  VRAM write enable.
REQ-023 mem_addr  out  ADDR_W  VRAM address.
REQ-024 mem_wdata  out  8  VRAM write data.
REQ-025 mem_rdata  in  8  VRAM read data; 1-cycle latency after mem_en with mem_we=0.

Function
REQ-026 The block shall issue at most one VRAM access per cycle: mem_en=1 exactly when one requester is granted, with mem_addr, mem_we and mem_wdata taken from the winner.
REQ-027 The CPU is eligible when cpu_req=1 and the CPU state is IDLE; states are IDLE and ACK.
REQ-028 Priority shall be: CPU if eligible and starve_cnt==STARVE_MAX; otherwise video if vid_req; otherwise CPU if eligible; otherwise fill if fill_busy.
REQ-029 starve_cnt shall increment, saturating at STARVE_MAX, on each cycle the CPU is eligible and not granted, and shall clear on a CPU grant.
REQ-030 On a CPU grant in cycle N, the CPU state shall enter ACK in N+1 and assert cpu_ack for exactly one cycle; for reads, cpu_rdata shall equal mem_rdata in N+1; state then returns to IDLE.
REQ-031 cpu_req shall be ignored during the ACK cycle, so a request held through the ack is not re-serviced.
REQ-032 On a video grant in cycle N, vid_rvalid=1 and vid_rdata=mem_rdata in N+1; vid_rvalid=0 otherwise.
REQ-033 fill_start while fill_busy=0 and fill_len!=0 shall capture fill_value and fill_len, clear fill_ptr to 0, and set fill_busy on the next cycle.
REQ-034 fill_start while fill_busy=0 and fill_len=0 shall have no effect.
REQ-035 fill_start while fill_busy=1 shall be ignored.
REQ-036 Each fill grant shall write fill_value at fill_ptr and then increment fill_ptr.
REQ-037 fill_busy shall clear on the cycle after the grant that writes address fill_len-1.
REQ-038 fill_len of 2^ADDR_W is not representable; a fill_len of 0 never fills.
REQ-039 A CPU write to an address the fill has not yet reached shall be overwritten later by the fill; this is defined behaviour.
REQ-040 vid_gnt shall be 0 whenever vid_req=0.

Reset
REQ-041 While reset=1 the block shall drive: mem_en=0, mem_we=0, vid_gnt=0, vid_rvalid=0, cpu_ack=0, fill_busy=0, CPU state IDLE, starve_cnt=0, fill_ptr=0, cpu_rdata=0, vid_rdata=0.
REQ-042 Reset asserted mid-fill or mid-ack shall abort the operation; no ack or further write shall follow reset release.

Verification
REQ-043 CPU write 0x12 to 0x0050 with video idle -> mem_we=1 at 0x0050 in cycle N; cpu_ack in N+1 only.
REQ-044 vid_req held continuously with a CPU read pending -> CPU granted on the cycle after it loses 8 consecutive times; vid_gnt=0 that cycle; cpu_rdata correct.
REQ-045 fill_start with fill_len=4, value 0x00, no other traffic -> writes to addresses 0..3 on 4 consecutive cycles; fill_busy falls after the 4th.
REQ-046 Fill of length 10 with a CPU read issued mid-fill -> CPU serviced first; fill resumes at the next address; total of 10 fill writes.
REQ-047 fill_start during fill_busy, and fill_start with fill_len=0 -> both ignored; no extra writes.
REQ-048 reset pulse mid-fill -> fill_busy=0 and no writes after release; a new fill_start is accepted normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: video fetch, CPU access and a background fill engine
// share one single-ported VRAM; CPU starvation is bounded by STARVE_MAX.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [7:0]        vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              fill_start,
  input  logic [7:0]        fill_value,
  input  logic [ADDR_W-1:0] fill_len,
  output logic              fill_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {
    CPU_IDLE = 1'b0,
    CPU_ACK  = 1'b1
  } cpu_state_t;

  cpu_state_t        cpu_state;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] fill_ptr;
  logic [ADDR_W-1:0] fill_len_q;
  logic [7:0]        fill_val_q;

  logic cpu_elig;
  logic starved;
  logic cpu_win;
  logic vid_win;
  logic fill_win;

  // Grant selection and VRAM port mux; nothing is granted while in reset
  always_comb begin
    cpu_elig  = cpu_req && (cpu_state == CPU_IDLE);
    starved   = (starve_cnt == SW'(STARVE_MAX));
    cpu_win   = 1'b0;
    vid_win   = 1'b0;
    fill_win  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (cpu_elig && starved) cpu_win = 1'b1;
      else if (vid_req)        vid_win = 1'b1;
      else if (cpu_elig)       cpu_win = 1'b1;
      else if (fill_busy)      fill_win = 1'b1;
    end
    if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vid_win) begin
      mem_addr  = vid_addr;
    end else if (fill_win) begin
      mem_addr  = fill_ptr;
      mem_wdata = fill_val_q;
    end
    mem_en  = cpu_win | vid_win | fill_win;
    mem_we  = (cpu_win & cpu_we) | fill_win;
    vid_gnt = vid_win;
  end

  // VRAM read data arrives one cycle after the access, when the valid flags are up
  assign vid_rdata = vid_rvalid ? mem_rdata : 8'h00;
  assign cpu_rdata = cpu_ack    ? mem_rdata : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_state  <= CPU_IDLE;
      starve_cnt <= '0;
      cpu_ack    <= 1'b0;
      vid_rvalid <= 1'b0;
      fill_busy  <= 1'b0;
      fill_ptr   <= '0;
      fill_len_q <= '0;
      fill_val_q <= '0;
    end else begin
      vid_rvalid <= vid_win;
      cpu_ack    <= cpu_win;

      case (cpu_state)
        CPU_IDLE: if (cpu_win) cpu_state <= CPU_ACK;
        CPU_ACK:  cpu_state <= CPU_IDLE;
        default:  cpu_state <= CPU_IDLE;
      endcase

      if (cpu_win)
        starve_cnt <= '0;
      else if (cpu_elig && !starved)
        starve_cnt <= starve_cnt + SW'(1);

      // A new fill is only accepted when idle and with a non-zero length
      if (!fill_busy) begin
        if (fill_start && (fill_len != '0)) begin
          fill_busy  <= 1'b1;
          fill_ptr   <= '0;
          fill_len_q <= fill_len;
          fill_val_q <= fill_value;
        end
      end else if (fill_win) begin
        fill_ptr <= fill_ptr + ADDR_W'(1);
        if (fill_ptr == fill_len_q - ADDR_W'(1))
          fill_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// traffic scored against a cycle-level model of the arbitration rules.
module tb_vram_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned SMAX = 8;

  logic          clk;
  logic          reset;
  logic          vid_req, vid_gnt, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_rdata;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          fill_start, fill_busy;
  logic [7:0]    fill_value;
  logic [AW-1:0] fill_len;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  int checks;
  int errors;

  logic [7:0] vram [0:65535];

  vram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_value(fill_value), .fill_len(fill_len),
    .fill_busy(fill_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port VRAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= vram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vid_req = 0; vid_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 0; fill_value = '0; fill_len = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    vid_req = 1; vid_addr = 16'h0010;
    cpu_req = 1; cpu_addr = 16'h0020;
    fill_start = 1; fill_len = 16'd5;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, vid_gnt, vid_rvalid, cpu_ack, fill_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {mem_en, mem_we, vid_gnt, vid_rvalid, cpu_ack, fill_busy});
    end
    checks++;
    if ({cpu_rdata, vid_rdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got %h exp 0000", {cpu_rdata, vid_rdata});
    end
    tick();
    idle_inputs();
    reset = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({fill_busy, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got %b exp 00", {fill_busy, mem_en});
    end
  endtask

  task automatic test_cpu_write();
    vram[16'h0050] = 8'hEE;
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 8'h12;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack} !== {2'b11, 16'h0050, 8'h12, 1'b0}) begin
      errors++;
      $display("FAIL cpu_wr_grant got en%b we%b a%h d%h ack%b exp en1 we1 a0050 d12 ack0",
               mem_en, mem_we, mem_addr, mem_wdata, cpu_ack);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({cpu_ack, mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL cpu_wr_ack got ack%b en%b exp ack1 en0", cpu_ack, mem_en);
    end
    tick();
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, mem_en} !== 2'b00 || vram[16'h0050] !== 8'h12) begin
      errors++;
      $display("FAIL cpu_wr_after got ack%b en%b mem%h exp ack0 en0 mem12",
               cpu_ack, mem_en, vram[16'h0050]);
    end
  endtask

  task automatic test_starve();
    int losses;
    vram[16'h1234] = 8'hA5;
    vram[16'h0100] = 8'h3C;
    tick();
    vid_req = 1; vid_addr = 16'h0100;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    losses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!vid_gnt) break;
      losses++;
      if (losses == 2) begin
        checks++;
        if ({vid_rvalid, vid_rdata} !== {1'b1, 8'h3C}) begin
          errors++;
          $display("FAIL vid_read got v%b d%h exp v1 d3c", vid_rvalid, vid_rdata);
        end
      end
      tick();
    end
    checks++;
    if (losses != int'(SMAX)) begin
      errors++;
      $display("FAIL starve_losses got %0d exp %0d", losses, SMAX);
    end
    checks++;
    if ({vid_gnt, mem_en, mem_we, mem_addr} !== {3'b010, 16'h1234}) begin
      errors++;
      $display("FAIL starve_grant got g%b en%b we%b a%h exp g0 en1 we0 a1234",
               vid_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_rdata, vid_gnt, vid_rvalid} !== {1'b1, 8'hA5, 2'b10}) begin
      errors++;
      $display("FAIL starve_ack got ack%b d%h g%b rv%b exp ack1 da5 g1 rv0",
               cpu_ack, cpu_rdata, vid_gnt, vid_rvalid);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL starve_ack_once got %b exp 0", cpu_ack);
    end
  endtask

  task automatic test_fill4();
    tick();
    fill_start = 1; fill_len = 16'd4; fill_value = 8'h00;
    tick();
    fill_start = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({fill_busy, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'(k), 8'h00}) begin
        errors++;
        $display("FAIL fill4_write%0d got b%b en%b we%b a%h d%h exp b1 en1 we1 a%h d00",
                 k, fill_busy, mem_en, mem_we, mem_addr, mem_wdata, 16'(k));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({fill_busy, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL fill4_done got b%b en%b exp b0 en0", fill_busy, mem_en);
    end
  endtask

  task automatic test_fill_cpu();
    int  nw;
    bit  seq_ok, raised, cpu_seen, ack_seen;
    vram[16'h2000] = 8'h5A;
    tick();
    fill_start = 1; fill_len = 16'd10; fill_value = 8'h77;
    tick();
    fill_start = 0;
    nw = 0; seq_ok = 1; raised = 0; cpu_seen = 0; ack_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (raised && !cpu_seen) begin
        cpu_seen = 1;
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h2000}) begin
          errors++;
          $display("FAIL fill_cpu_first got en%b we%b a%h exp en1 we0 a2000",
                   mem_en, mem_we, mem_addr);
        end
      end else if (mem_en && mem_we) begin
        if (mem_addr !== 16'(nw) || mem_wdata !== 8'h77) seq_ok = 0;
        nw++;
      end
      if (cpu_ack) begin
        ack_seen = 1;
        checks++;
        if (cpu_rdata !== 8'h5A) begin
          errors++;
          $display("FAIL fill_cpu_rdata got %h exp 5a", cpu_rdata);
        end
      end
      if (!fill_busy) break;
      tick();
      if (ack_seen) cpu_req = 0;
      if (nw == 4 && !raised) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2000; raised = 1;
      end
    end
    checks++;
    if (nw != 10 || !seq_ok || !ack_seen || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_cpu_total got writes %0d seq %0d ack %0d busy %b exp 10 1 1 0",
               nw, seq_ok, ack_seen, fill_busy);
    end
    idle_inputs();
  endtask

  task automatic test_fill_ignored();
    int nw;
    bit data_ok, quiet;
    tick();
    fill_start = 1; fill_len = 16'd3; fill_value = 8'h11;
    tick();
    fill_start = 1; fill_len = 16'd8; fill_value = 8'h99;
    nw = 0; data_ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en && mem_we) begin
        if (mem_wdata !== 8'h11 || mem_addr !== 16'(nw)) data_ok = 0;
        nw++;
      end
      if (!fill_busy) break;
      tick();
      fill_start = 0;
    end
    checks++;
    if (nw != 3 || !data_ok) begin
      errors++;
      $display("FAIL fill_busy_start got writes %0d ok %0d exp 3 1", nw, data_ok);
    end
    tick();
    fill_start = 1; fill_len = 16'd0; fill_value = 8'h55;
    tick();
    fill_start = 0;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fill_busy !== 1'b0 || mem_en !== 1'b0) quiet = 0;
      tick();
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL fill_len0 got activity exp none");
    end
  endtask

  task automatic test_reset_mid_fill();
    int nw;
    bit quiet;
    tick();
    fill_start = 1; fill_len = 16'd20; fill_value = 8'hAB;
    tick();
    fill_start = 0;
    tick(); tick(); tick();
    reset = 1;
    tick();
    @(negedge clk);
    checks++;
    if ({fill_busy, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_fill got b%b en%b exp b0 en0", fill_busy, mem_en);
    end
    tick();
    reset = 0;
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fill_busy !== 1'b0 || mem_en !== 1'b0 || cpu_ack !== 1'b0) quiet = 0;
      tick();
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_abort got activity after release exp none");
    end
    fill_start = 1; fill_len = 16'd2; fill_value = 8'hC3;
    tick();
    fill_start = 0;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en && mem_we && mem_addr === 16'(nw) && mem_wdata === 8'hC3) nw++;
      if (!fill_busy) break;
      tick();
    end
    checks++;
    if (nw != 2 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL refill got writes %0d busy %b exp 2 0", nw, fill_busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] sh [0:63];
    int   m_lose, m_fill_rem, m_fill_ptr, w;
    bit   m_ack, m_ack_rd, m_vrv, prev_ack, prev_vgnt, elig, busy_now;
    logic [7:0] m_ack_data, m_vdata, m_fill_val, e_wd;
    logic [AW-1:0] e_addr;
    logic e_we;
    for (int a = 0; a < 64; a++) begin
      sh[a] = 8'($urandom);
      vram[a] = sh[a];
    end
    reset = 1; idle_inputs();
    tick(); tick();
    reset = 0;
    m_lose = 0; m_fill_rem = 0; m_fill_ptr = 0; m_fill_val = '0;
    m_ack = 0; m_ack_rd = 0; m_ack_data = '0; m_vrv = 0; m_vdata = '0;
    prev_ack = 0; prev_vgnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!vid_req || prev_vgnt) begin
        vid_req  = ($urandom_range(2) == 0);
        vid_addr = AW'($urandom_range(63));
      end
      if (!cpu_req || prev_ack) begin
        cpu_req   = ($urandom_range(1) == 0);
        cpu_we    = ($urandom_range(1) == 0);
        cpu_addr  = AW'($urandom_range(63));
        cpu_wdata = 8'($urandom);
      end
      fill_start = ($urandom_range(11) == 0);
      fill_len   = AW'($urandom_range(6));
      fill_value = 8'($urandom);
      @(negedge clk);
      elig = cpu_req && !m_ack;
      busy_now = (m_fill_rem > 0);
      if (elig && m_lose == int'(SMAX)) w = 1;
      else if (vid_req)                 w = 2;
      else if (elig)                    w = 1;
      else if (busy_now)                w = 3;
      else                              w = 0;
      e_addr = '0; e_we = 0; e_wd = '0;
      if (w == 1) begin e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata; end
      if (w == 2) e_addr = vid_addr;
      if (w == 3) begin e_addr = AW'(m_fill_ptr); e_we = 1; e_wd = m_fill_val; end
      checks++;
      if ({vid_gnt, mem_en, fill_busy} !== {(w == 2), (w != 0), busy_now}) begin
        errors++;
        $display("FAIL rnd_grant cyc %0d got g%b en%b b%b exp g%b en%b b%b",
                 cyc, vid_gnt, mem_en, fill_busy, (w == 2), (w != 0), busy_now);
      end
      if (w != 0) begin
        checks++;
        if (mem_addr !== e_addr || mem_we !== e_we || (e_we && mem_wdata !== e_wd)) begin
          errors++;
          $display("FAIL rnd_port cyc %0d got a%h we%b d%h exp a%h we%b d%h",
                   cyc, mem_addr, mem_we, mem_wdata, e_addr, e_we, e_wd);
        end
      end
      checks++;
      if (cpu_ack !== m_ack || (m_ack && m_ack_rd && cpu_rdata !== m_ack_data)) begin
        errors++;
        $display("FAIL rnd_cpu cyc %0d got ack%b d%h exp ack%b d%h",
                 cyc, cpu_ack, cpu_rdata, m_ack, m_ack_data);
      end
      checks++;
      if (vid_rvalid !== m_vrv || (m_vrv && vid_rdata !== m_vdata)) begin
        errors++;
        $display("FAIL rnd_vid cyc %0d got v%b d%h exp v%b d%h",
                 cyc, vid_rvalid, vid_rdata, m_vrv, m_vdata);
      end
      // Advance the reference model by one cycle
      prev_ack = m_ack;
      m_ack = (w == 1);
      if (w == 1) begin
        m_lose = 0;
        m_ack_rd = !cpu_we;
        if (cpu_we) sh[cpu_addr[5:0]] = cpu_wdata;
        else        m_ack_data = sh[cpu_addr[5:0]];
      end else if (elig && m_lose < int'(SMAX)) begin
        m_lose++;
      end
      m_vrv = (w == 2);
      prev_vgnt = (w == 2);
      if (w == 2) m_vdata = sh[vid_addr[5:0]];
      if (w == 3) begin
        sh[m_fill_ptr] = m_fill_val;
        m_fill_ptr++;
        m_fill_rem--;
      end
      if (fill_start && !busy_now && fill_len != '0) begin
        m_fill_rem = int'(fill_len);
        m_fill_ptr = 0;
        m_fill_val = fill_value;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_rdata = '0;
    for (int a = 0; a < 65536; a++) vram[a] = 8'hFF;
    idle_inputs();
    reset = 1;
    test_reset();
    test_cpu_write();
    test_starve();
    test_fill4();
    test_fill_cpu();
    test_fill_ignored();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
